// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset vector, redirect
// source encodings and fetch FSM state encoding.
package if_stage_pkg;

   localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      PCS_SEQ    = 2'b00,
      PCS_JR     = 2'b01,
      PCS_JUMP   = 2'b10,
      PCS_BRANCH = 2'b11
   } pcsource_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10,
      S_HOLD = 2'b11
   } if_state_e;

   function automatic logic [31:0] slot_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_redirect_buf.sv
// One-entry pending redirect: selects the decode-stage target and remembers it
// together with the delay-slot address until the slot request is accepted.
module if_redirect_buf
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        br_valid,
   input  logic [1:0]  pcsource,
   input  logic [31:0] id_pc,
   input  logic [31:0] bpc,
   input  logic [31:0] jpc,
   input  logic [31:0] jrpc,
   input  logic        load,
   input  logic        clear,
   output logic        br_take,
   output logic [31:0] br_target,
   output logic [31:0] br_slot,
   output logic        pend_valid,
   output logic [31:0] pend_target,
   output logic [31:0] pend_slot
);

   always_comb begin
      br_take   = br_valid && (pcsource_e'(pcsource) != PCS_SEQ);
      br_slot   = slot_pc(id_pc);
      br_target = 32'h0;
      unique case (pcsource_e'(pcsource))
         PCS_BRANCH: br_target = bpc;
         PCS_JUMP:   br_target = jpc;
         PCS_JR:     br_target = jrpc;
         default:    br_target = 32'h0;
      endcase
   end

   // A fresh load wins over a clear from consuming the previous entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid  <= 1'b0;
         pend_target <= 32'h0;
         pend_slot   <= 32'h0;
      end else begin
         if (clear)
            pend_valid <= 1'b0;
         if (load) begin
            pend_valid  <= 1'b1;
            pend_target <= br_target;
            pend_slot   <= br_slot;
         end
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with one outstanding SRAM-like request, delay-slot
// aware redirects and flush. Define IF_ADEL_CHECK_EN for misaligned-fetch flagging.
//
// state | meaning
// IDLE  | first cycle after reset, nothing issued
// REQ   | request fetch_pc, wait for addr_ok
// WAIT  | request accepted, wait for data_ok
// HOLD  | fetched word offered to decode
module if_stage
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        id_allowin,
   output logic        if_to_id_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        br_valid,
   input  logic [1:0]  pcsource,
   input  logic [31:0] id_pc,
   input  logic [31:0] bpc,
   input  logic [31:0] jpc,
   input  logic [31:0] jrpc,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata
`ifdef IF_ADEL_CHECK_EN
   ,
   output logic        if_adel
`endif
);

   if_state_e   state, state_nx;
   logic [31:0] fetch_pc, fetch_nx;
   logic [31:0] issued_pc;
   logic        issued_valid;
   logic        discard;
   logic        adel_hit;
   logic        fire, transfer, direct, consume, load, clear;
   logic        br_take, pend_valid;
   logic [31:0] br_target, br_slot, pend_target, pend_slot;

   if_redirect_buf u_redirect_buf (
      .clk         (clk),
      .rst         (rst),
      .br_valid    (br_valid),
      .pcsource    (pcsource),
      .id_pc       (id_pc),
      .bpc         (bpc),
      .jpc         (jpc),
      .jrpc        (jrpc),
      .load        (load),
      .clear       (clear),
      .br_take     (br_take),
      .br_target   (br_target),
      .br_slot     (br_slot),
      .pend_valid  (pend_valid),
      .pend_target (pend_target),
      .pend_slot   (pend_slot)
   );

`ifdef IF_ADEL_CHECK_EN
   assign adel_hit = (state == S_REQ) && (fetch_pc[1:0] != 2'b00);
`else
   assign adel_hit = 1'b0;
`endif

   // A stale response still owed from before reset blocks new requests so that
   // only one request is ever outstanding.
   always_comb begin
      inst_req       = (state == S_REQ) && !adel_hit && !discard;
      inst_addr      = inst_req ? fetch_pc : 32'h0;
      if_to_id_valid = (state == S_HOLD);
      fire           = inst_req && inst_addr_ok;
      transfer       = if_to_id_valid && id_allowin;
      direct         = br_take && (fire ? (fetch_pc == br_slot)
                                        : (issued_valid && issued_pc == br_slot));
      consume        = !flush && fire && pend_valid && (fetch_pc == pend_slot);
      load           = br_take && !flush && !direct;
      clear          = flush || consume;
   end

   always_comb begin
      fetch_nx = fetch_pc;
      if (flush)
         fetch_nx = flush_pc;
      else if (direct)
         fetch_nx = br_target;
      else if (fire)
         fetch_nx = consume ? pend_target : fetch_pc + 32'd4;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: state_nx = S_REQ;
         S_REQ: begin
            if (fire)
               state_nx = S_WAIT;
            else if (adel_hit && !flush)
               state_nx = S_HOLD;
         end
         S_WAIT: begin
            if (inst_data_ok)
               state_nx = (discard || flush) ? S_REQ : S_HOLD;
         end
         S_HOLD: begin
            if (flush || transfer)
               state_nx = S_REQ;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         fetch_pc     <= RESET_VEC;
         issued_pc    <= 32'h0;
         issued_valid <= 1'b0;
         discard      <= (state == S_WAIT);
         if_pc        <= 32'h0;
         if_inst      <= 32'h0;
      end else begin
         state    <= state_nx;
         fetch_pc <= fetch_nx;
         if (fire) begin
            issued_pc    <= fetch_pc;
            issued_valid <= 1'b1;
         end
         if (flush)
            issued_valid <= 1'b0;
         if (inst_data_ok)
            discard <= 1'b0;
         if (flush && (fire || (state == S_WAIT && !inst_data_ok)))
            discard <= 1'b1;
         if (state == S_WAIT && inst_data_ok && !discard && !flush) begin
            if_inst <= inst_rdata;
            if_pc   <= issued_pc;
         end else if (adel_hit && !flush) begin
            if_inst <= 32'h0;
            if_pc   <= fetch_pc;
         end
      end
   end

`ifdef IF_ADEL_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)
         if_adel <= 1'b0;
      else if (state == S_WAIT && inst_data_ok && !discard && !flush)
         if_adel <= 1'b0;
      else if (adel_hit && !flush)
         if_adel <= 1'b1;
      else if (flush)
         if_adel <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential stream table, redirect table and
// hand-written stall / flush / reset sequences against a small memory model.
module tb_if_stage;
   import if_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_allowin;
   logic        if_to_id_valid;
   logic [31:0] if_pc, if_inst;
   logic        br_valid;
   logic [1:0]  pcsource;
   logic [31:0] id_pc, bpc, jpc, jrpc;
   logic        flush;
   logic [31:0] flush_pc;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
`ifdef IF_ADEL_CHECK_EN
   logic        if_adel;
`endif

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .id_allowin     (id_allowin),
      .if_to_id_valid (if_to_id_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
      .br_valid       (br_valid),
      .pcsource       (pcsource),
      .id_pc          (id_pc),
      .bpc            (bpc),
      .jpc            (jpc),
      .jrpc           (jrpc),
      .flush          (flush),
      .flush_pc       (flush_pc),
      .inst_req       (inst_req),
      .inst_addr      (inst_addr),
      .inst_addr_ok   (inst_addr_ok),
      .inst_data_ok   (inst_data_ok),
      .inst_rdata     (inst_rdata)
`ifdef IF_ADEL_CHECK_EN
      ,
      .if_adel        (if_adel)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   bit          mem_busy = 1'b0;
   int          mem_cnt  = 0;
   int          data_lat = 1;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] req_log[$];
   logic [31:0] xpc[$];
   logic [31:0] xinst[$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } xfer_t;

   typedef struct {
      logic [31:0] cur;
      logic [1:0]  pcs;
      logic [31:0] tgt;
      logic [31:0] exp_next;
   } redir_t;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock: present memory responses, log handshakes, advance to posedge+1.
   task automatic step();
      inst_data_ok = mem_busy && (mem_cnt == 0);
      inst_rdata   = inst_data_ok ? memf(mem_addr) : 32'hDEAD_BEEF;
      inst_addr_ok = (inst_req === 1'b1) && !mem_busy;
      #1;
      if (inst_req === 1'b1 && inst_addr_ok)
         req_log.push_back(inst_addr);
      if (if_to_id_valid === 1'b1 && id_allowin) begin
         xpc.push_back(if_pc);
         xinst.push_back(if_inst);
      end
      if (inst_data_ok)
         mem_busy = 1'b0;
      else if (mem_busy)
         mem_cnt--;
      if (inst_req === 1'b1 && inst_addr_ok) begin
         mem_busy = 1'b1;
         mem_addr = inst_addr;
         mem_cnt  = data_lat - 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_reqs(input int n, input string name);
      int k = 0;
      while (req_log.size() < n && k < 300) begin step(); k++; end
      if (req_log.size() < n) chk(name, req_log.size(), n);
   endtask

   task automatic run_until_xfers(input int n, input string name);
      int k = 0;
      while (xpc.size() < n && k < 300) begin step(); k++; end
      if (xpc.size() < n) chk(name, xpc.size(), n);
   endtask

   task automatic wait_hold(input logic [31:0] pc);
      int k = 0;
      while (!(if_to_id_valid === 1'b1 && if_pc === pc) && k < 300) begin step(); k++; end
      if (k >= 300) chk("wait_hold timeout", if_pc, pc);
   endtask

   task automatic wait_req(input logic [31:0] addr);
      int k = 0;
      while (!(inst_req === 1'b1 && inst_addr === addr) && k < 300) begin step(); k++; end
      if (k >= 300) chk("wait_req timeout", inst_addr, addr);
   endtask

   xfer_t  stream_tbl[4];
   redir_t redir_tbl[4];

   initial begin
      int r0, x0;
      logic [31:0] hp, hi;

      for (int i = 0; i < 4; i++) begin
         stream_tbl[i].pc   = RESET_VEC + 32'(4 * i);
         stream_tbl[i].inst = memf(RESET_VEC + 32'(4 * i));
      end
      redir_tbl[0] = '{32'hBFC0_0010, 2'b11, 32'hBFC0_0100, 32'hBFC0_0100};
      redir_tbl[1] = '{32'hBFC0_0104, 2'b10, 32'hBFC0_0200, 32'hBFC0_0200};
      redir_tbl[2] = '{32'hBFC0_0204, 2'b01, 32'hBFC0_0040, 32'hBFC0_0040};
      redir_tbl[3] = '{32'hBFC0_0044, 2'b00, 32'hBFC0_0800, 32'hBFC0_0048 + 32'd4};

      rst = 1'b1; id_allowin = 1'b1; br_valid = 1'b0; pcsource = 2'b00;
      id_pc = 32'h0; bpc = 32'h0; jpc = 32'h0; jrpc = 32'h0;
      flush = 1'b0; flush_pc = 32'h0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
      repeat (3) step();

      chk("reset valid", if_to_id_valid, 1'b0);
      chk("reset if_pc", if_pc, 32'h0);
      chk("reset if_inst", if_inst, 32'h0);
      chk("reset inst_req", inst_req, 1'b0);
      chk("reset inst_addr", inst_addr, 32'h0);

      // sequential stream after reset release
      rst = 1'b0;
      run_until_xfers(4, "stream timeout");
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stream req %0d", i), req_log[i], stream_tbl[i].pc);
         chk($sformatf("stream pc %0d", i), xpc[i], stream_tbl[i].pc);
         chk($sformatf("stream inst %0d", i), xinst[i], stream_tbl[i].inst);
      end

      // redirects raised while the branch sits in decode, slot not yet requested
      for (int i = 0; i < 4; i++) begin
         wait_hold(redir_tbl[i].cur);
         r0 = req_log.size();
         br_valid = 1'b1; pcsource = redir_tbl[i].pcs; id_pc = redir_tbl[i].cur;
         bpc  = (redir_tbl[i].pcs == 2'b11) ? redir_tbl[i].tgt : 32'h1111_1110;
         jpc  = (redir_tbl[i].pcs == 2'b10) ? redir_tbl[i].tgt : 32'h2222_2220;
         jrpc = (redir_tbl[i].pcs == 2'b01) ? redir_tbl[i].tgt : 32'h3333_3330;
         if (redir_tbl[i].pcs == 2'b00) bpc = redir_tbl[i].tgt;
         step();
         br_valid = 1'b0;
         run_until_reqs(r0 + 2, "redir timeout");
         chk($sformatf("redir %0d slot", i), req_log[r0], redir_tbl[i].cur + 32'd4);
         chk($sformatf("redir %0d next", i), req_log[r0 + 1], redir_tbl[i].exp_next);
      end

      // branch arrives in the same cycle the slot request is accepted
      wait_req(32'hBFC0_0050);
      r0 = req_log.size();
      br_valid = 1'b1; pcsource = 2'b11; id_pc = 32'hBFC0_004C; bpc = 32'hBFC0_0600;
      step();
      br_valid = 1'b0;
      data_lat = 3;
      run_until_reqs(r0 + 2, "direct fire timeout");
      chk("direct fire slot", req_log[r0], 32'hBFC0_0050);
      chk("direct fire next", req_log[r0 + 1], 32'hBFC0_0600);

      // jump arrives while the slot request is already waiting for data
      wait_req(32'hBFC0_0604);
      r0 = req_log.size();
      step();
      br_valid = 1'b1; pcsource = 2'b10; id_pc = 32'hBFC0_0600; jpc = 32'hBFC0_0700;
      step();
      br_valid = 1'b0;
      run_until_reqs(r0 + 2, "direct wait timeout");
      chk("direct wait slot", req_log[r0], 32'hBFC0_0604);
      chk("direct wait next", req_log[r0 + 1], 32'hBFC0_0700);
      data_lat = 1;

      // decode stall for 5 cycles in HOLD
      id_allowin = 1'b0;
      begin
         int k = 0;
         while (if_to_id_valid !== 1'b1 && k < 100) begin step(); k++; end
      end
      hp = if_pc; hi = if_inst;
      r0 = req_log.size(); x0 = xpc.size();
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("stall pc %0d", i), if_pc, hp);
         chk($sformatf("stall inst %0d", i), if_inst, hi);
      end
      chk("stall valid", if_to_id_valid, 1'b1);
      chk("stall no req", req_log.size(), r0);
      id_allowin = 1'b1;
      step();
      chk("stall release count", xpc.size(), x0 + 1);
      chk("stall release pc", xpc[x0], hp);
      chk("stall valid drop", if_to_id_valid, 1'b0);

      // flush while waiting for data
      data_lat = 3;
      begin
         int k = 0;
         while (inst_req !== 1'b1 && k < 100) begin step(); k++; end
      end
      step();
      x0 = xpc.size(); r0 = req_log.size();
      flush = 1'b1; flush_pc = 32'hBFC0_0380;
      step();
      flush = 1'b0;
      data_lat = 1;
      run_until_xfers(x0 + 1, "flush wait timeout");
      chk("flush wait req", req_log[r0], 32'hBFC0_0380);
      chk("flush wait pc", xpc[x0], 32'hBFC0_0380);
      chk("flush wait inst", xinst[x0], memf(32'hBFC0_0380));

      // flush beats a simultaneous branch
      wait_hold(32'hBFC0_0384);
      r0 = req_log.size();
      id_allowin = 1'b0;
      flush = 1'b1; flush_pc = 32'hBFC0_0380;
      br_valid = 1'b1; pcsource = 2'b11; id_pc = 32'hBFC0_0384; bpc = 32'hBFC0_0900;
      step();
      flush = 1'b0; br_valid = 1'b0; id_allowin = 1'b1;
      run_until_reqs(r0 + 4, "flush br timeout");
      chk("flush br req0", req_log[r0], 32'hBFC0_0380);
      chk("flush br req1", req_log[r0 + 1], 32'hBFC0_0384);
      chk("flush br req2", req_log[r0 + 2], 32'hBFC0_0388);
      chk("flush br req3", req_log[r0 + 3], 32'hBFC0_038C);

      // reset while a response is outstanding
      data_lat = 3;
      begin
         int k = 0;
         while (inst_req !== 1'b1 && k < 100) begin step(); k++; end
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      r0 = req_log.size(); x0 = xpc.size();
      run_until_xfers(x0 + 1, "reset wait timeout");
      chk("reset wait req", req_log[r0], RESET_VEC);
      chk("reset wait pc", xpc[x0], RESET_VEC);
      chk("reset wait inst", xinst[x0], memf(RESET_VEC));
      data_lat = 1;

`ifdef IF_ADEL_CHECK_EN
      wait_hold(32'hBFC0_0008);
      r0 = req_log.size();
      br_valid = 1'b1; pcsource = 2'b01; id_pc = 32'hBFC0_0008; jrpc = 32'h0040_0002;
      step();
      br_valid = 1'b0;
      begin
         int k = 0;
         while (!(if_to_id_valid === 1'b1 && if_adel === 1'b1) && k < 100) begin step(); k++; end
      end
      chk("adel flag", if_adel, 1'b1);
      chk("adel pc", if_pc, 32'h0040_0002);
      chk("adel inst", if_inst, 32'h0);
      chk("adel req count", req_log.size(), r0 + 1);
      chk("adel slot req", req_log[r0], 32'hBFC0_000C);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
